// File: rtl/maquina_input_sequencer_if.sv
// Switch/FSM-side signal bundle for maquina_input_sequencer.
// The master drives the raw switches and clr_drop; the slave (sequencer) drives everything else.
interface maquina_input_sequencer_if;
  logic [3:0] sw_raw;
  logic       clr_drop;
  logic [3:0] fsm_sw;
  logic       busy;
  logic [1:0] grant_id;
  logic [3:0] pending;
  logic [3:0] drop;

  modport master (
    output sw_raw,
    output clr_drop,
    input  fsm_sw,
    input  busy,
    input  grant_id,
    input  pending,
    input  drop
  );

  modport slave (
    input  sw_raw,
    input  clr_drop,
    output fsm_sw,
    output busy,
    output grant_id,
    output pending,
    output drop
  );
endinterface

// File: rtl/maquina_input_sequencer.sv
// Synchronize, debounce and serialize the {P,R,N,D} switches into one-hot FSM pulses.
// Optional macro SEQ_ROUND_ROBIN_EN selects round-robin instead of fixed-priority arbitration.
module maquina_input_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int GAP_CYCLES      = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  maquina_input_sequencer_if.slave    bus
);

  localparam int DB_W  = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MAXPG = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXPG < 2) ? 1 : $clog2(MAXPG);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       stable_q, stable_d;
  logic [DB_W-1:0]  db_cnt_q [4];
  logic [DB_W-1:0]  db_cnt_d [4];
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       drop_q, drop_d;
  logic [3:0]       fsm_sw_q, fsm_sw_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [3:0]       press_s;
  logic [3:0]       clear_s;
  logic [1:0]       win_s;

  function automatic logic [1:0] pick_fixed(input logic [3:0] req);
    logic [1:0] idx;
    if (req[3]) begin
      idx = 2'd3;
    end else if (req[2]) begin
      idx = 2'd2;
    end else if (req[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

`ifdef SEQ_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  // Descending scan so the nearest requester after ptr is the last one written.
  function automatic logic [1:0] pick_rr(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    idx = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        idx = cand;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  always_comb begin
    win_s = pick_rr(pending_q, rr_ptr_q);
  end

  always_comb begin
    if ((state_q == S_IDLE) && (pending_q != 4'd0)) begin
      rr_ptr_d = win_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= 2'd3;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  always_comb begin
    win_s = pick_fixed(pending_q);
  end
`endif

  // Per-channel debounce: accept a new level only after DEBOUNCE_CYCLES disagreeing samples.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
    press_s = stable_d & ~stable_q;
  end

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    fsm_sw_d    = fsm_sw_q;
    grant_id_d  = grant_id_q;
    clear_s     = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (pending_q != 4'd0) begin
          state_d     = S_DRIVE;
          fsm_sw_d    = 4'd1 << win_s;
          clear_s     = 4'd1 << win_s;
          grant_id_d  = win_s;
          pulse_cnt_d = PULSE_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (pulse_cnt_q == '0) begin
          fsm_sw_d = 4'd0;
          if (GAP_CYCLES > 0) begin
            state_d     = S_GAP;
            pulse_cnt_d = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (pulse_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        fsm_sw_d = 4'd0;
      end
    endcase
  end

  // A press on the same edge as its grant re-arms pending and is not counted as a drop.
  always_comb begin
    pending_d = (pending_q & ~clear_s) | press_s;
    if (bus.clr_drop) begin
      drop_d = press_s & pending_q & ~clear_s;
    end else begin
      drop_d = drop_q | (press_s & pending_q & ~clear_s);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync1_q     <= 4'd0;
      sync2_q     <= 4'd0;
      stable_q    <= 4'd0;
      pending_q   <= 4'd0;
      drop_q      <= 4'd0;
      fsm_sw_q    <= 4'd0;
      grant_id_q  <= 2'd0;
      busy_q      <= 1'b0;
      pulse_cnt_q <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.sw_raw;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      fsm_sw_q    <= fsm_sw_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
      pulse_cnt_q <= pulse_cnt_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign bus.fsm_sw   = fsm_sw_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_id_q;
  assign bus.pending  = pending_q;
  assign bus.drop     = drop_q;

endmodule

// File: tb/tb_maquina_input_sequencer.sv
// Directed bench for maquina_input_sequencer with DEBOUNCE=4, PULSE=2, GAP=3.
// Edge numbers in comments count rising edges after the stimulus change.
module tb_maquina_input_sequencer;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  maquina_input_sequencer_if seq_if ();

  maquina_input_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (2),
    .GAP_CYCLES     (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (seq_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic [3:0] all_ord [4];
  logic [1:0] all_id0;
  logic [3:0] sim_first, sim_second;
  logic [3:0] drop_first, drop_second;

  initial begin
`ifdef SEQ_ROUND_ROBIN_EN
    all_ord[0] = 4'b0001; all_ord[1] = 4'b0010; all_ord[2] = 4'b0100; all_ord[3] = 4'b1000;
    all_id0 = 2'd0;
    sim_first = 4'b0001; sim_second = 4'b1000;
    drop_first = 4'b0100; drop_second = 4'b1000;
`else
    all_ord[0] = 4'b1000; all_ord[1] = 4'b0100; all_ord[2] = 4'b0010; all_ord[3] = 4'b0001;
    all_id0 = 2'd3;
    sim_first = 4'b1000; sim_second = 4'b0001;
    drop_first = 4'b1000; drop_second = 4'b0100;
`endif
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    seq_if.sw_raw   = 4'b1111;
    seq_if.clr_drop = 1'b0;

    // Reset with all switches held: outputs stay zero, then four fresh presses.
    tick(1);
    check("rst_outs_1", {seq_if.fsm_sw, seq_if.busy, seq_if.grant_id, seq_if.pending, seq_if.drop}, 32'd0);
    tick(1);
    check("rst_outs_2", {seq_if.fsm_sw, seq_if.busy, seq_if.grant_id, seq_if.pending, seq_if.drop}, 32'd0);
    reset = 1'b0;
    tick(5);
    check("held_pend_e5", {28'd0, seq_if.pending}, 32'h0);
    tick(1);
    check("held_pend_e6", {28'd0, seq_if.pending}, 32'hF);
    tick(1);
    check("held_grant0", {28'd0, seq_if.fsm_sw}, {28'd0, all_ord[0]});
    check("held_id0", {30'd0, seq_if.grant_id}, {30'd0, all_id0});
    for (int g = 1; g < 4; g++) begin
      tick(6);
      check("held_grant_n", {28'd0, seq_if.fsm_sw}, {28'd0, all_ord[g]});
    end
    seq_if.sw_raw = 4'b0000;
    tick(14);
    check("held_done", {28'd0, seq_if.pending, seq_if.busy}, 32'd0);

    // Single D press timing.
    do_reset();
    seq_if.sw_raw = 4'b0001;
    tick(5);
    check("d_pend_e5", {28'd0, seq_if.pending}, 32'h0);
    tick(1);
    check("d_pend_e6", {28'd0, seq_if.pending}, 32'h1);
    check("d_sw_e6", {28'd0, seq_if.fsm_sw}, 32'h0);
    tick(1);
    check("d_sw_e7", {28'd0, seq_if.fsm_sw}, 32'h1);
    check("d_busy_e7", {31'd0, seq_if.busy}, 32'd1);
    check("d_id_e7", {30'd0, seq_if.grant_id}, 32'd0);
    check("d_pend_e7", {28'd0, seq_if.pending}, 32'h0);
    tick(1);
    check("d_sw_e8", {28'd0, seq_if.fsm_sw}, 32'h1);
    tick(1);
    check("d_sw_e9", {28'd0, seq_if.fsm_sw}, 32'h0);
    check("d_busy_e9", {31'd0, seq_if.busy}, 32'd1);
    tick(2);
    check("d_busy_e11", {31'd0, seq_if.busy}, 32'd1);
    tick(1);
    check("d_busy_e12", {31'd0, seq_if.busy}, 32'd0);
    seq_if.sw_raw = 4'b0000;
    tick(10);

    // Three-sample glitch on N must be rejected.
    seq_if.sw_raw = 4'b0010;
    tick(3);
    seq_if.sw_raw = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check("glitch_quiet", {24'd0, seq_if.pending, seq_if.fsm_sw}, 32'd0);
    end

    // Simultaneous P and D.
    do_reset();
    seq_if.sw_raw = 4'b1001;
    tick(7);
    check("sim_first", {28'd0, seq_if.fsm_sw}, {28'd0, sim_first});
    tick(6);
    check("sim_second", {28'd0, seq_if.fsm_sw}, {28'd0, sim_second});
    seq_if.sw_raw = 4'b0000;
    tick(12);

    // Drop: a solo N grant first, then N re-pressed while queued behind two grants.
    do_reset();
    seq_if.sw_raw = 4'b0010;
    tick(7);
    check("drop_pre_n", {28'd0, seq_if.fsm_sw}, 32'h2);
    seq_if.sw_raw = 4'b0000;
    tick(8);
    seq_if.sw_raw = 4'b1110;
    tick(6);
    check("drop_pend_e6", {28'd0, seq_if.pending}, 32'hE);
    seq_if.sw_raw = 4'b1100;
    tick(1);
    check("drop_first", {28'd0, seq_if.fsm_sw}, {28'd0, drop_first});
    tick(5);
    seq_if.sw_raw = 4'b1110;
    tick(1);
    check("drop_second", {28'd0, seq_if.fsm_sw}, {28'd0, drop_second});
    tick(4);
    check("drop_e17", {28'd0, seq_if.drop}, 32'h0);
    tick(1);
    check("drop_e18", {28'd0, seq_if.drop}, 32'h2);
    check("drop_pend_e18", {28'd0, seq_if.pending}, 32'h2);
    tick(1);
    check("drop_n_pulse", {28'd0, seq_if.fsm_sw}, 32'h2);
    check("drop_pend_e19", {28'd0, seq_if.pending}, 32'h0);
    tick(2);
    for (int k = 0; k < 14; k++) begin
      check("drop_no_repeat", {24'd0, seq_if.pending, seq_if.fsm_sw}, 32'd0);
      tick(1);
    end
    check("drop_sticky", {28'd0, seq_if.drop}, 32'h2);
    seq_if.clr_drop = 1'b1;
    tick(1);
    seq_if.clr_drop = 1'b0;
    check("drop_cleared", {28'd0, seq_if.drop}, 32'h0);
    seq_if.sw_raw = 4'b0000;
    tick(10);

    // Reset on the first DRIVE cycle, switch still held.
    do_reset();
    seq_if.sw_raw = 4'b0001;
    tick(7);
    check("mid_drive_sw", {28'd0, seq_if.fsm_sw}, 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_outs", {24'd0, seq_if.fsm_sw, seq_if.pending}, 32'd0);
    check("mid_rst_busy", {31'd0, seq_if.busy}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check("mid_quiet", {24'd0, seq_if.fsm_sw, seq_if.pending}, 32'd0);
    end
    tick(1);
    check("mid_repend", {28'd0, seq_if.pending}, 32'h1);
    tick(1);
    check("mid_regrant", {28'd0, seq_if.fsm_sw}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
